// File: rtl/qspi_pkg.sv
// Shared QSPI master types: FSM states, lane modes and the lane-count helper.
package qspi_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, PH_A, PH_B, HOLD, TURN} state_e;

   typedef enum logic [1:0] {
      LM_SINGLE = 2'b00,
      LM_DUAL   = 2'b01,
      LM_QUAD   = 2'b10,
      LM_RSVD   = 2'b11
   } lane_mode_e;

   // Reserved mode falls back to a single lane.
   function automatic logic [2:0] lane_count(input lane_mode_e mode);
      case (mode)
         LM_DUAL: lane_count = 3'd2;
         LM_QUAD: lane_count = 3'd4;
         default: lane_count = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/qspi_lane_shifter.sv
// Transfer word shifter: loads (optionally bit-reversed) TX data, presents the current beat on io_out,
// shifts received beats in at the bottom; io[L-1] always carries the most significant bit of a beat.
module qspi_lane_shifter
   import qspi_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  lane_mode_e        i_mode,
   input  logic              i_lsb_first,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_load_dat,
   input  logic              i_sample,
   input  logic              i_shift,
   input  logic [3:0]        i_io_in,
   output logic [3:0]        o_io_out,
   output logic [DATA_W-1:0] o_rx_dat
);

   logic [DATA_W-1:0] r_sr;
   logic [3:0]        r_io_out;
   logic [DATA_W-1:0] w_load_val;
   logic [DATA_W-1:0] w_sampled;

   function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
      for (int i = 0; i < DATA_W; i++) bit_rev[i] = v[DATA_W-1-i];
   endfunction

   function automatic logic [3:0] top_beat(input logic [DATA_W-1:0] v, input lane_mode_e m);
      case (lane_count(m))
         3'd4:    top_beat = v[DATA_W-1 -: 4];
         3'd2:    top_beat = {2'b00, v[DATA_W-1 -: 2]};
         default: top_beat = {3'b000, v[DATA_W-1]};
      endcase
   endfunction

   // Sampling pushes the already-driven TX beat out of the top, so one register serves both directions.
   always_comb begin
      w_load_val = i_lsb_first ? bit_rev(i_load_dat) : i_load_dat;
      case (lane_count(i_mode))
         3'd4:    w_sampled = (r_sr << 4) | DATA_W'(i_io_in);
         3'd2:    w_sampled = (r_sr << 2) | DATA_W'(i_io_in[1:0]);
         default: w_sampled = (r_sr << 1) | DATA_W'(i_io_in[1]);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr     <= '0;
         r_io_out <= '0;
      end else if (i_load) begin
         r_sr     <= w_load_val;
         r_io_out <= top_beat(w_load_val, i_mode);
      end else if (i_sample) begin
         r_sr     <= w_sampled;
      end else if (i_shift) begin
         r_io_out <= top_beat(r_sr, i_mode);
      end
   end

   assign o_io_out = r_io_out;
   assign o_rx_dat = i_lsb_first ? bit_rev(r_sr) : r_sr;

endmodule

// File: rtl/qspi_master_ctrl.sv
// SPI/QSPI master with 1/2/4 lanes, all CPOL/CPHA modes and programmable SS setup/hold/turnaround.
// Accepts start only when ready; pad outputs are registered and sclk is built from the next state.
module qspi_master_ctrl
   import qspi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 2,
   parameter int CNT_W  = 16,
   localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] din,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic [1:0]        lane_mode,
   input  logic              dir,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [CNT_W-1:0]  dvsr,
   input  logic [CNT_W-1:0]  ss_s_cycle,
   input  logic [CNT_W-1:0]  ss_h_cycle,
   input  logic [CNT_W-1:0]  ss_t_cycle,
   input  logic [3:0]        io_in,
   output logic [3:0]        io_out,
   output logic [3:0]        io_oe,
   output logic              sclk,
   output logic [NUM_CS-1:0] ss_n,
   output logic [DATA_W-1:0] dout,
   output logic              ready,
   output logic              done_tick
);

   localparam int BW = $clog2(DATA_W);

   state_e            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, r_dvsr, r_ss_s, r_ss_h, r_ss_t;
   logic [BW-1:0]     r_beat, w_beats_m1;
   lane_mode_e        r_mode, w_mode;
   logic              r_dir, r_cpol, r_cpha, r_lsb;
   logic              w_lsb, w_cpol, w_multi_wr;
   logic              w_accept, w_cnt_clr, w_sample, w_shift, w_last_hold;
   logic [NUM_CS-1:0] r_ss_n, w_ss_dec;
   logic [3:0]        r_io_oe, w_oe_dec;
   logic              r_sclk, w_sclk_nxt, r_done;
   logic [DATA_W-1:0] r_dout, w_rx;

   // In IDLE the live inputs are what gets latched, so downstream logic sees them directly.
   assign w_mode     = (r_state == IDLE) ? lane_mode_e'(lane_mode) : r_mode;
   assign w_lsb      = (r_state == IDLE) ? lsb_first : r_lsb;
   assign w_cpol     = (r_state == IDLE) ? cpol : r_cpol;
   assign w_multi_wr = (lane_count(r_mode) != 3'd1) && !r_dir;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_cnt_clr   = 1'b0;
      w_sample    = 1'b0;
      w_shift     = 1'b0;
      w_last_hold = 1'b0;
      case (r_state)
         IDLE:  if (start) begin
                   w_state_nxt = SETUP;
                   w_accept    = 1'b1;
                   w_cnt_clr   = 1'b1;
                end
         SETUP: if (r_cnt == r_ss_s) begin
                   w_state_nxt = PH_A;
                   w_cnt_clr   = 1'b1;
                end
         PH_A:  if (r_cnt == r_dvsr) begin
                   w_state_nxt = PH_B;
                   w_cnt_clr   = 1'b1;
                   w_sample    = 1'b1;
                end
         PH_B:  if (r_cnt == r_dvsr) begin
                   w_cnt_clr = 1'b1;
                   if (r_beat == w_beats_m1) begin
                      w_state_nxt = HOLD;
                   end else begin
                      w_state_nxt = PH_A;
                      w_shift     = 1'b1;
                   end
                end
         HOLD:  if (r_cnt == r_ss_h) begin
                   w_state_nxt = TURN;
                   w_cnt_clr   = 1'b1;
                   w_last_hold = 1'b1;
                end
         TURN:  if (r_cnt == r_ss_t) begin
                   w_state_nxt = IDLE;
                   w_cnt_clr   = 1'b1;
                end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_ss_dec = '1;
      for (int i = 0; i < NUM_CS; i++)
         if (cs_sel == CS_W'(i)) w_ss_dec[i] = 1'b0;
      case (lane_count(w_mode))
         3'd4:    w_oe_dec = dir ? 4'h0 : 4'hF;
         3'd2:    w_oe_dec = dir ? 4'h0 : 4'h3;
         default: w_oe_dec = 4'h1;
      endcase
      case (lane_count(r_mode))
         3'd4:    w_beats_m1 = BW'(DATA_W/4 - 1);
         3'd2:    w_beats_m1 = BW'(DATA_W/2 - 1);
         default: w_beats_m1 = BW'(DATA_W - 1);
      endcase
      case (w_state_nxt)
         PH_A:    w_sclk_nxt = w_cpol ^ r_cpha;
         PH_B:    w_sclk_nxt = ~(w_cpol ^ r_cpha);
         default: w_sclk_nxt = w_cpol;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_beat  <= '0;
         r_mode  <= LM_SINGLE;
         r_dir   <= 1'b0;
         r_cpol  <= 1'b0;
         r_cpha  <= 1'b0;
         r_lsb   <= 1'b0;
         r_dvsr  <= '0;
         r_ss_s  <= '0;
         r_ss_h  <= '0;
         r_ss_t  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (w_cnt_clr || r_state == IDLE) ? '0 : r_cnt + CNT_W'(1);
         if (w_accept) begin
            r_beat <= '0;
            r_mode <= lane_mode_e'(lane_mode);
            r_dir  <= dir;
            r_cpol <= cpol;
            r_cpha <= cpha;
            r_lsb  <= lsb_first;
            r_dvsr <= dvsr;
            r_ss_s <= ss_s_cycle;
            r_ss_h <= ss_h_cycle;
            r_ss_t <= ss_t_cycle;
         end else if (w_shift) begin
            r_beat <= r_beat + BW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ss_n  <= '1;
         r_io_oe <= '0;
         r_sclk  <= 1'b0;
         r_done  <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_sclk <= w_sclk_nxt;
         r_done <= w_last_hold;
         if (w_accept) begin
            r_ss_n  <= w_ss_dec;
            r_io_oe <= w_oe_dec;
         end else if (w_last_hold) begin
            r_ss_n  <= '1;
            r_io_oe <= '0;
         end
         if (w_last_hold && !w_multi_wr) r_dout <= w_rx;
      end
   end

   qspi_lane_shifter #(.DATA_W(DATA_W)) u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_mode     (w_mode),
      .i_lsb_first(w_lsb),
      .i_load     (w_accept),
      .i_load_dat (din),
      .i_sample   (w_sample),
      .i_shift    (w_shift),
      .i_io_in    (io_in),
      .o_io_out   (io_out),
      .o_rx_dat   (w_rx)
   );

   assign io_oe     = r_io_oe;
   assign sclk      = r_sclk;
   assign ss_n      = r_ss_n;
   assign dout      = r_dout;
   assign ready     = (r_state == IDLE);
   assign done_tick = r_done;

endmodule
